multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/riscv_pkg.sv | 88 ++++++++
 rtl/control_unit.sv | 63 ++++++
 rtl/multicycle_ctrl.sv | 145 ++++++++++++++
 tb/tb_multicycle_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared encodings for the multicycle controller: FSM states, RV opcodes, instruction
// classes, ALU operation codes and the wb_sel / pc_src mux encodings.
package riscv_pkg;

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StTrap   = 3'd5
  } state_e;

  localparam logic [6:0] OpcOp     = 7'b0110011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcJalr   = 7'b1100111;
  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;

  typedef enum logic [3:0] {
    ClsIllegal,
    ClsOp,
    ClsOpImm,
    ClsLoad,
    ClsStore,
    ClsBranch,
    ClsJal,
    ClsJalr,
    ClsLui,
    ClsAuipc
  } op_class_e;

  localparam logic [1:0] WbAlu = 2'd0;
  localparam logic [1:0] WbMem = 2'd1;
  localparam logic [1:0] WbPc4 = 2'd2;
  localparam logic [1:0] WbImm = 2'd3;

  localparam logic [1:0] PcPlus4 = 2'd0;
  localparam logic [1:0] PcImm   = 2'd1;
  localparam logic [1:0] PcAlu   = 2'd2;

  // Native ALU code width; the top zero-extends to ALU_CTRL_BITS.
  localparam int unsigned AluCodeWidth = 4;
  typedef logic [AluCodeWidth-1:0] alu_op_t;

  localparam alu_op_t AluAdd  = 4'd0;
  localparam alu_op_t AluSub  = 4'd1;
  localparam alu_op_t AluSll  = 4'd2;
  localparam alu_op_t AluSlt  = 4'd3;
  localparam alu_op_t AluSltu = 4'd4;
  localparam alu_op_t AluXor  = 4'd5;
  localparam alu_op_t AluSrl  = 4'd6;
  localparam alu_op_t AluSra  = 4'd7;
  localparam alu_op_t AluOr   = 4'd8;
  localparam alu_op_t AluAnd  = 4'd9;
  localparam alu_op_t AluBeq  = 4'd10;
  localparam alu_op_t AluBne  = 4'd11;
  localparam alu_op_t AluBlt  = 4'd12;
  localparam alu_op_t AluBge  = 4'd13;
  localparam alu_op_t AluBltu = 4'd14;
  localparam alu_op_t AluBgeu = 4'd15;

  // alt selects SUB for funct3=000 and SRA for funct3=101.
  function automatic alu_op_t alu_from_funct3(logic [2:0] funct3, logic alt);
    alu_op_t op;
    unique case (funct3)
      3'b000:  op = alt ? AluSub : AluAdd;
      3'b001:  op = AluSll;
      3'b010:  op = AluSlt;
      3'b011:  op = AluSltu;
      3'b100:  op = AluXor;
      3'b101:  op = alt ? AluSra : AluSrl;
      3'b110:  op = AluOr;
      default: op = AluAnd;
    endcase
    return op;
  endfunction

  function automatic logic r_type_legal(logic [6:0] funct7, logic [2:0] funct3);
    return (funct7 == 7'h00) ||
           ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
  endfunction

endpackage

// File: rtl/control_unit.sv
// Combinational instruction decode: instruction class, ALU operation and load/store
// sign/width, all taken straight from the instruction register.
module control_unit
  import riscv_pkg::*;
(
  input  logic [31:0] instr,
  output op_class_e   op_class,
  output alu_op_t     alu_op,
  output logic        mem_sign,
  output logic [1:0]  mem_width
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       unused_instr_bits;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  // Register specifiers and immediates are routed elsewhere in the datapath.
  assign unused_instr_bits = ^{instr[24:15], instr[11:7]};

  assign mem_sign  = funct3[2];
  assign mem_width = funct3[1:0];

  always_comb begin
    op_class = ClsIllegal;
    alu_op   = AluAdd;
    case (opcode)
      OpcOp: begin
        op_class = r_type_legal(funct7, funct3) ? ClsOp : ClsIllegal;
        alu_op   = alu_from_funct3(funct3, instr[30]);
      end
      OpcOpImm: begin
        op_class = ClsOpImm;
        // Only shifts use bit 30; for ADDI it is just immediate data.
        alu_op   = alu_from_funct3(funct3, (funct3 == 3'b101) && instr[30]);
      end
      OpcLoad:  op_class = ClsLoad;
      OpcStore: op_class = ClsStore;
      OpcBranch: begin
        op_class = ClsBranch;
        case (funct3)
          3'b000:  alu_op = AluBeq;
          3'b001:  alu_op = AluBne;
          3'b100:  alu_op = AluBlt;
          3'b101:  alu_op = AluBge;
          3'b110:  alu_op = AluBltu;
          3'b111:  alu_op = AluBgeu;
          default: alu_op = AluAdd;
        endcase
      end
      OpcJal:   op_class = ClsJal;
      OpcJalr:  op_class = ClsJalr;
      OpcLui:   op_class = ClsLui;
      OpcAuipc: op_class = ClsAuipc;
      default:  op_class = ClsIllegal;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV control FSM: FETCH/DECODE/EXEC/MEM/WB with a sticky TRAP state and a
// retired-instruction counter that advances on every PC update.
module multicycle_ctrl
  import riscv_pkg::*;
#(
  parameter int unsigned REG_WIDTH     = 64,
  parameter int unsigned ALU_CTRL_BITS = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              instr,
  input  logic                     imem_ack,
  input  logic                     dmem_ack,
  input  logic                     branch_taken,
  output logic                     imem_req,
  output logic                     ir_write,
  output logic                     dmem_req,
  output logic                     dmem_we,
  output logic                     mem_sign,
  output logic [1:0]               mem_width,
  output logic [ALU_CTRL_BITS-1:0] alu_ctrl,
  output logic                     alu_a_sel,
  output logic                     rf_we,
  output logic [1:0]               wb_sel,
  output logic                     pc_write,
  output logic [1:0]               pc_src,
  output logic [REG_WIDTH-1:0]     instret,
  output logic                     halted
);

  state_e                 state_q, state_d;
  logic [REG_WIDTH-1:0]   instret_q;
  op_class_e              op_class;
  alu_op_t                alu_op;
  logic                   in_instr;

  control_unit u_control_unit (
    .instr     (instr),
    .op_class  (op_class),
    .alu_op    (alu_op),
    .mem_sign  (mem_sign),
    .mem_width (mem_width)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StFetch;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      if (pc_write) begin
        instret_q <= instret_q + REG_WIDTH'(1);
      end
    end
  end

  assign instret = instret_q;

  // All enables are gated by rst so an outstanding request drops in the reset cycle.
  always_comb begin
    state_d   = state_q;
    imem_req  = 1'b0;
    ir_write  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    rf_we     = 1'b0;
    wb_sel    = WbAlu;
    pc_write  = 1'b0;
    pc_src    = PcPlus4;
    halted    = 1'b0;
    in_instr  = 1'b0;
    if (!rst) begin
      unique case (state_q)
        StFetch: begin
          imem_req = 1'b1;
          if (imem_ack) begin
            ir_write = 1'b1;
            state_d  = StDecode;
          end
        end
        StDecode: begin
          in_instr = 1'b1;
          state_d  = (op_class == ClsIllegal) ? StTrap : StExec;
        end
        StExec: begin
          in_instr = 1'b1;
          case (op_class)
            ClsLoad, ClsStore: state_d = StMem;
            ClsBranch: begin
              pc_write = 1'b1;
              pc_src   = branch_taken ? PcImm : PcPlus4;
              state_d  = StFetch;
            end
            default: state_d = StWb;
          endcase
        end
        StMem: begin
          in_instr = 1'b1;
          dmem_req = 1'b1;
          dmem_we  = (op_class == ClsStore);
          if (dmem_ack) begin
            if (op_class == ClsStore) begin
              pc_write = 1'b1;
              pc_src   = PcPlus4;
              state_d  = StFetch;
            end else begin
              state_d = StWb;
            end
          end
        end
        StWb: begin
          in_instr = 1'b1;
          rf_we    = 1'b1;
          pc_write = 1'b1;
          state_d  = StFetch;
          case (op_class)
            ClsLoad: wb_sel = WbMem;
            ClsLui:  wb_sel = WbImm;
            ClsJal: begin
              wb_sel = WbPc4;
              pc_src = PcImm;
            end
            ClsJalr: begin
              wb_sel = WbPc4;
              pc_src = PcAlu;
            end
            default: wb_sel = WbAlu;
          endcase
        end
        StTrap: halted = 1'b1;
        default: state_d = StFetch;
      endcase
    end
  end

  always_comb begin
    alu_ctrl  = '0;
    alu_a_sel = 1'b0;
    if (in_instr) begin
      alu_ctrl  = ALU_CTRL_BITS'(alu_op);
      alu_a_sel = (op_class == ClsAuipc);
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: instruction-level step model plus directed
// literal checks, followed by randomized instructions, acks and resets.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr = 32'h0;
  logic        imem_ack = 1'b0, dmem_ack = 1'b0, branch_taken = 1'b0;
  logic        imem_req, ir_write, dmem_req, dmem_we, mem_sign, alu_a_sel, rf_we;
  logic        pc_write, halted;
  logic [1:0]  mem_width, wb_sel, pc_src;
  logic [4:0]  alu_ctrl;
  logic [7:0]  instret;

  multicycle_ctrl #(.REG_WIDTH(8), .ALU_CTRL_BITS(5)) dut (
    .clk(clk), .rst(rst), .instr(instr), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
    .branch_taken(branch_taken), .imem_req(imem_req), .ir_write(ir_write),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .mem_sign(mem_sign), .mem_width(mem_width),
    .alu_ctrl(alu_ctrl), .alu_a_sel(alu_a_sel), .rf_we(rf_we), .wb_sel(wb_sel),
    .pc_write(pc_write), .pc_src(pc_src), .instret(instret), .halted(halted)
  );

  always #5 clk = ~clk;

  // One instruction: its bits, the ordered list of steps it walks through, and what
  // it must present on the outputs.
  typedef struct {
    logic [31:0] ins;
    logic [39:0] seq;
    int          len;
    int          alu;
    bit          chk_alu;
    bit          auipc;
    bit          store;
    logic [1:0]  wb;
    logic [1:0]  ps;
  } ins_t;

  int rf3  [10] = '{0, 0, 1, 2, 3, 4, 5, 5, 6, 7};
  int rf7  [10] = '{0, 32, 0, 0, 0, 0, 0, 32, 0, 0};
  int ralu [10] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9};
  int ialu [8]  = '{0, 2, 3, 4, 5, 6, 8, 9};
  int bf3  [6]  = '{0, 1, 4, 5, 6, 7};

  int   n_cmp = 0;
  int   n_bad = 0;
  ins_t prog_q[$];
  ins_t m_cur;
  int   m_pos = 0;
  int   m_instret = 0;
  bit   m_valid = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic ins_t gen(input int kind, input int v);
    ins_t t;
    logic [31:0] w;
    logic [6:0]  f7, op;
    logic [2:0]  f3;
    bit alt;
    w = $urandom;
    t.chk_alu = 1; t.alu = 0; t.auipc = 0; t.store = 0; t.wb = 2'd0; t.ps = 2'd0;
    t.seq = "FDEW"; t.len = 4;
    case (kind)
      0: begin w[6:0] = 7'h33; w[14:12] = 3'(rf3[v]); w[31:25] = 7'(rf7[v]); t.alu = ralu[v]; end
      1: begin
        f7 = 7'($urandom_range(0, 127)); f3 = 3'($urandom_range(0, 7));
        if (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))) f7 = 7'h01;
        w[6:0] = 7'h33; w[14:12] = f3; w[31:25] = f7;
        t.seq = "FDT"; t.len = 3; t.chk_alu = 0;
      end
      2: begin
        w[6:0] = 7'h13; w[14:12] = 3'(v); t.alu = ialu[v];
        if (v == 1) w[31:25] = 7'h00;
        if (v == 5) begin
          alt = 1'($urandom_range(0, 1));
          w[31:25] = alt ? 7'h20 : 7'h00;
          t.alu = alt ? 7 : 6;
        end
      end
      3: begin w[6:0] = 7'h03; w[14:12] = 3'($urandom_range(0, 6)); t.seq = "FDEMW"; t.len = 5; t.wb = 2'd1; end
      4: begin w[6:0] = 7'h23; w[14:12] = 3'($urandom_range(0, 3)); t.seq = "FDEM"; t.store = 1; end
      5: begin w[6:0] = 7'h63; w[14:12] = 3'(bf3[v]); t.alu = 10 + v; t.seq = "FDE"; t.len = 3; end
      6: begin w[6:0] = 7'h6F; t.wb = 2'd2; t.ps = 2'd1; end
      7: begin w[6:0] = 7'h67; w[14:12] = 3'd0; t.wb = 2'd2; t.ps = 2'd2; end
      8: begin w[6:0] = 7'h37; t.wb = 2'd3; end
      9: begin w[6:0] = 7'h17; t.auipc = 1; end
      default: begin
        do op = 7'($urandom_range(0, 127));
        while (op inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17});
        w[6:0] = op; t.seq = "FDT"; t.len = 3; t.chk_alu = 0;
      end
    endcase
    t.ins = w;
    return t;
  endfunction

  function automatic ins_t next_instr();
    int r, k;
    if (prog_q.size() > 0) return prog_q.pop_front();
    r = $urandom_range(0, 99);
    if (r < 3) return gen(1, 0);
    if (r < 6) return gen(10, 0);
    k = $urandom_range(0, 8);
    if (k == 0) return gen(0, $urandom_range(0, 9));
    if (k == 1) return gen(2, $urandom_range(0, 7));
    if (k == 4) return gen(5, $urandom_range(0, 5));
    return gen(k + 1, 0);
  endfunction

  function automatic byte cur_step();
    if (m_pos == 0) return "F";
    return m_cur.seq[8*(m_cur.len-1-m_pos) +: 8];
  endfunction

  // Model: a step completes when its handshake (if any) arrives; finishing the last
  // step of an instruction retires it.
  always @(posedge clk) begin : model
    bit  fetched;
    bit  done;
    byte c;
    fetched = 0;
    if (rst) begin
      m_valid = 1; m_pos = 0; m_instret = 0;
    end else if (m_valid) begin
      c = cur_step();
      done = (c == "F") ? imem_ack : (c == "M") ? dmem_ack : (c == "T") ? 1'b0 : 1'b1;
      if (done) begin
        if (c == "F") begin
          m_cur = next_instr(); m_pos = 1; fetched = 1;
        end else if (m_pos == m_cur.len - 1) begin
          m_instret = (m_instret + 1) % 256; m_pos = 0;
        end else begin
          m_pos++;
        end
      end
    end
    if (fetched) begin
      #1;
      instr = m_cur.ins;
    end
  end

  always @(negedge clk) begin : compare
    byte c;
    bit  done, last, body;
    logic e_ireq, e_irw, e_dreq, e_dwe, e_rfwe, e_pcw, e_halt, e_asel;
    logic [1:0] e_pcs;
    if (m_valid) begin
      c = cur_step();
      done = (c == "F") ? imem_ack : (c == "M") ? dmem_ack : (c == "T") ? 1'b0 : 1'b1;
      last = (m_pos > 0) && (m_pos == m_cur.len - 1) && (c != "T");
      body = (c == "D") || (c == "E") || (c == "M") || (c == "W");
      e_ireq = !rst && c == "F";
      e_irw  = e_ireq && imem_ack;
      e_dreq = !rst && c == "M";
      e_dwe  = e_dreq && m_cur.store;
      e_rfwe = !rst && c == "W";
      e_pcw  = !rst && last && done;
      e_halt = !rst && c == "T";
      e_asel = !rst && body && m_cur.auipc;
      e_pcs  = (c == "E") ? {1'b0, branch_taken} : (c == "W") ? m_cur.ps : 2'd0;
      check("imem_req", imem_req, e_ireq);
      check("ir_write", ir_write, e_irw);
      check("dmem_req", dmem_req, e_dreq);
      check("dmem_we", dmem_we, e_dwe);
      check("rf_we", rf_we, e_rfwe);
      check("pc_write", pc_write, e_pcw);
      check("halted", halted, e_halt);
      check("alu_a_sel", alu_a_sel, e_asel);
      check("mem_sign", mem_sign, instr[14]);
      check("mem_width", mem_width, instr[13:12]);
      if (e_rfwe) check("wb_sel", wb_sel, m_cur.wb);
      if (e_pcw) check("pc_src", pc_src, e_pcs);
      if (!rst && body && m_cur.chk_alu) check("alu_ctrl", alu_ctrl, 64'(m_cur.alu));
      if (!rst) check("instret", instret, 64'(m_instret));
    end
  end

  task automatic cyc(input logic ia, input logic da, input logic bt, input logic r);
    @(posedge clk);
    #2;
    imem_ack = ia; dmem_ack = da; branch_taken = bt; rst = r;
    @(negedge clk);
    #1;
  endtask

  initial begin
    ins_t t;
    t = gen(0, 0); t.ins = 32'h002081B3; prog_q.push_back(t);
    t = gen(3, 0); t.ins = 32'h0000A183; prog_q.push_back(t);
    t = gen(5, 0); t.ins = 32'h00000063; prog_q.push_back(t); prog_q.push_back(t);
    t = gen(10, 0); t.ins = 32'h00000073; prog_q.push_back(t);
    t = gen(4, 0); t.ins = 32'h0020A023; prog_q.push_back(t);

    cyc(1, 1, 0, 1);
    cyc(1, 1, 0, 1);
    check("lit_rst_imem_req", imem_req, 0);
    // add x3,x1,x2 with immediate acks
    cyc(1, 0, 0, 0);
    check("lit_first_imem_req", imem_req, 1);
    check("lit_first_ir_write", ir_write, 1);
    cyc(1, 0, 0, 0); cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
    check("lit_add_rf_we", rf_we, 1);
    check("lit_add_wb_sel", wb_sel, 0);
    cyc(1, 0, 0, 0);
    check("lit_add_instret", instret, 1);
    // lw with dmem_ack three cycles late
    cyc(1, 0, 0, 0); cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
    check("lit_lw_dmem_req", dmem_req, 1);
    check("lit_lw_dmem_we", dmem_we, 0);
    check("lit_lw_width", mem_width, 2);
    check("lit_lw_sign", mem_sign, 0);
    check("lit_lw_no_imem_req", imem_req, 0);
    cyc(1, 0, 0, 0); cyc(1, 0, 0, 0); cyc(1, 1, 0, 0);
    check("lit_lw_dmem_req_held", dmem_req, 1);
    cyc(1, 0, 0, 0);
    check("lit_lw_rf_we", rf_we, 1);
    check("lit_lw_wb_sel", wb_sel, 1);
    cyc(1, 0, 0, 0);
    check("lit_lw_instret", instret, 2);
    // beq taken, then not taken
    cyc(1, 0, 0, 0); cyc(1, 0, 1, 0);
    check("lit_beq1_pc_write", pc_write, 1);
    check("lit_beq1_pc_src", pc_src, 1);
    check("lit_beq1_rf_we", rf_we, 0);
    cyc(1, 0, 0, 0); cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
    check("lit_beq2_pc_write", pc_write, 1);
    check("lit_beq2_pc_src", pc_src, 0);
    cyc(1, 0, 0, 0);
    check("lit_beq_instret", instret, 4);
    // ecall traps after decode
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      cyc(1, 1, 1, 0);
      check("lit_trap_halted", halted, 1);
      check("lit_trap_imem_req", imem_req, 0);
    end
    check("lit_trap_instret", instret, 4);
    // sw interrupted by reset in MEM; the late ack must be ignored
    cyc(0, 0, 0, 1);
    cyc(1, 0, 0, 0); cyc(0, 0, 0, 0); cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    check("lit_sw_dmem_req", dmem_req, 1);
    check("lit_sw_dmem_we", dmem_we, 1);
    cyc(0, 0, 0, 1);
    check("lit_rst_mem_dmem_req", dmem_req, 0);
    cyc(0, 1, 0, 0);
    check("lit_after_rst_dmem_req", dmem_req, 0);
    check("lit_after_rst_imem_req", imem_req, 1);
    check("lit_after_rst_pc_write", pc_write, 0);
    check("lit_after_rst_instret", instret, 0);
    // instret wrap on an 8-bit build via back-to-back branches
    prog_q.delete();
    t = gen(5, 0); t.ins = 32'h00000063;
    for (int i = 0; i < 260; i++) prog_q.push_back(t);
    cyc(0, 0, 0, 1);
    for (int i = 0; i < 766; i++) cyc(1, 0, 0, 0);
    check("lit_wrap_ff", instret, 8'hFF);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0);
    check("lit_wrap_00", instret, 8'h00);
    prog_q.delete();
    // random instructions, acks and resets
    for (int i = 0; i < 4000; i++) begin
      cyc(1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 4), 1'($urandom_range(0, 1)),
          ($urandom_range(0, 59) == 0));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
